// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, fault causes, FSM states
// and the legality check used when decoding a request.
package load_store_unit_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    localparam logic [1:0] LSU_CAUSE_MISALIGNED = 2'd0;
    localparam logic [1:0] LSU_CAUSE_ILLEGAL    = 2'd1;
    localparam logic [1:0] LSU_CAUSE_BUS_ERR    = 2'd2;
    localparam logic [1:0] LSU_CAUSE_RETRY      = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUS   = 2'd1;
    localparam logic [1:0] ST_RETRY = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Stores only have signed-less byte/half/word; loads add the unsigned byte/half forms.
    function automatic logic lsu_legal(input logic store, input logic [2:0] funct3);
        if (store)
            return (funct3 == FUNCT3_SB) || (funct3 == FUNCT3_SH) || (funct3 == FUNCT3_SW);
        return (funct3 == FUNCT3_LB) || (funct3 == FUNCT3_LH) || (funct3 == FUNCT3_LW) ||
               (funct3 == FUNCT3_LBU) || (funct3 == FUNCT3_LHU);
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering for stores, lane extraction plus sign/zero extension for loads,
// and alignment/legality decode. Purely combinational.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic        store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] dat_i,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sext;

    always_comb begin
        illegal_o = !lsu_legal(store_i, funct3_i);
        sext      = !funct3_i[2];
        byte_v    = dat_i[{addr_lo_i, 3'b000} +: 8];
        half_v    = dat_i[{addr_lo_i[1], 4'b0000} +: 16];
        case (funct3_i[1:0])
            2'b00: begin
                sel_o        = 4'b0001 << addr_lo_i;
                dat_o        = {4{wdata_i[7:0]}};
                misaligned_o = 1'b0;
                rdata_o      = {{24{sext & byte_v[7]}}, byte_v};
            end
            2'b01: begin
                sel_o        = 4'b0011 << {addr_lo_i[1], 1'b0};
                dat_o        = {2{wdata_i[15:0]}};
                misaligned_o = addr_lo_i[0];
                rdata_o      = {{16{sext & half_v[15]}}, half_v};
            end
            default: begin
                sel_o        = 4'b1111;
                dat_o        = wdata_i;
                misaligned_o = |addr_lo_i;
                rdata_o      = dat_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request from execute and runs one classic Wishbone
// cycle with retry and timeout handling, reporting data or a fault cause.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int RETRY_LIMIT    = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_store_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [1:0]  rsp_cause_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i
);

    localparam logic [7:0]  RTY_MAX  = 8'(RETRY_LIMIT);
    localparam logic [15:0] WAIT_MAX = 16'(TIMEOUT_CYCLES - 1);
    localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);

    logic [1:0]  state_q, state_d;
    logic        cyc_q, cyc_d, we_q, we_d, store_q, store_d, err_q, err_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d, rdata_q, rdata_d;
    logic [3:0]  sel_q, sel_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d, cause_q, cause_d;
    logic [7:0]  rty_cnt_q, rty_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;

    logic        idle;
    logic [3:0]  a_sel;
    logic [31:0] a_dat, a_rdata;
    logic        a_mis, a_ill;

    assign idle = (state_q == ST_IDLE);

    // Decode from the live request while idle; afterwards the captured request drives
    // the load extract so upstream may change its inputs during the bus cycle.
    load_store_unit_align u_align (
        .store_i      (idle ? req_store_i : store_q),
        .funct3_i     (idle ? req_funct3_i : funct3_q),
        .addr_lo_i    (idle ? req_addr_i[1:0] : addr_lo_q),
        .wdata_i      (req_wdata_i),
        .dat_i        (dat_i),
        .sel_o        (a_sel),
        .dat_o        (a_dat),
        .rdata_o      (a_rdata),
        .misaligned_o (a_mis),
        .illegal_o    (a_ill)
    );

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        store_d    = store_q;
        err_d      = err_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rdata_d    = rdata_q;
        sel_d      = sel_q;
        funct3_d   = funct3_q;
        addr_lo_d  = addr_lo_q;
        cause_d    = cause_q;
        rty_cnt_d  = rty_cnt_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: if (req_valid_i) begin
                store_d   = req_store_i;
                funct3_d  = req_funct3_i;
                addr_lo_d = req_addr_i[1:0];
                rdata_d   = '0;
                err_d     = 1'b0;
                cause_d   = '0;
                if (a_ill) begin
                    err_d   = 1'b1;
                    cause_d = LSU_CAUSE_ILLEGAL;
                    state_d = ST_RESP;
                end else if (a_mis) begin
                    err_d   = 1'b1;
                    cause_d = LSU_CAUSE_MISALIGNED;
                    state_d = ST_RESP;
                end else begin
                    adr_d      = {req_addr_i[31:2], 2'b00};
                    sel_d      = a_sel;
                    dat_d      = a_dat;
                    we_d       = req_store_i;
                    cyc_d      = 1'b1;
                    rty_cnt_d  = '0;
                    wait_cnt_d = '0;
                    state_d    = ST_BUS;
                end
            end
            ST_BUS: begin
                // ack wins over err, err over rty, all over the timeout
                if (ack_i) begin
                    cyc_d   = 1'b0;
                    rdata_d = store_q ? 32'd0 : a_rdata;
                    state_d = ST_RESP;
                end else if (err_i) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    cause_d = LSU_CAUSE_BUS_ERR;
                    state_d = ST_RESP;
                end else if (rty_i) begin
                    cyc_d = 1'b0;
                    if (rty_cnt_q == RTY_MAX) begin
                        err_d   = 1'b1;
                        cause_d = LSU_CAUSE_RETRY;
                        state_d = ST_RESP;
                    end else begin
                        rty_cnt_d = rty_cnt_q + 8'd1;
                        state_d   = ST_RETRY;
                    end
                end else if (TO_EN && wait_cnt_q == WAIT_MAX) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    cause_d = LSU_CAUSE_BUS_ERR;
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ST_RETRY: begin
                cyc_d      = 1'b1;
                wait_cnt_d = '0;
                state_d    = ST_BUS;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            store_q    <= 1'b0;
            err_q      <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            rdata_q    <= '0;
            sel_q      <= '0;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
            cause_q    <= '0;
            rty_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            store_q    <= store_d;
            err_q      <= err_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rdata_q    <= rdata_d;
            sel_q      <= sel_d;
            funct3_q   <= funct3_d;
            addr_lo_q  <= addr_lo_d;
            cause_q    <= cause_d;
            rty_cnt_q  <= rty_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign req_ready_o = idle;
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_rdata_o = rsp_valid_o ? rdata_q : 32'd0;
    assign rsp_err_o   = rsp_valid_o & err_q;
    assign rsp_cause_o = rsp_valid_o ? cause_q : 2'd0;
    assign cyc_o       = cyc_q;
    assign stb_o       = cyc_q;
    assign we_o        = we_q;
    assign adr_o       = adr_q;
    assign sel_o       = sel_q;
    assign dat_o       = dat_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: Wishbone memory slave plus a byte-level reference memory,
// directed scenarios followed by randomized loads/stores.
module tb_load_store_unit;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        req_valid_i = 1'b0, req_store_i = 1'b0;
    logic [2:0]  req_funct3_i = '0;
    logic [31:0] req_addr_i = '0, req_wdata_i = '0;
    logic        req_ready_o, rsp_valid_o, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_cause_o;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i = '0;
    logic        ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;

    always #5 clk_i = ~clk_i;

    load_store_unit #(.RETRY_LIMIT(3), .TIMEOUT_CYCLES(255)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
        .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .rsp_cause_o(rsp_cause_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .adr_o(adr_o), .sel_o(sel_o), .dat_o(dat_o), .dat_i(dat_i),
        .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    int vectors = 0, miscompares = 0;

    logic [31:0] smem [16];
    logic [7:0]  rmem [64];

    int s_delay = 0, s_rty = 0, s_lat = 0;
    bit s_noresp = 1'b0, s_both = 1'b0;

    // Wishbone slave: optional wait states, a number of rty terminations, or silence.
    always @(negedge clk_i) begin
        ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
        if (cyc_o && stb_o && !rst_i) begin
            dat_i = smem[adr_o[5:2]];
            if (!s_noresp) begin
                if (s_lat < s_delay) s_lat++;
                else begin
                    s_lat = 0;
                    if (s_rty > 0) begin
                        rty_i = 1'b1;
                        s_rty--;
                    end else begin
                        ack_i = 1'b1;
                        err_i = s_both;
                        if (we_o)
                            for (int i = 0; i < 4; i++)
                                if (sel_o[i]) smem[adr_o[5:2]][8*i +: 8] = dat_o[8*i +: 8];
                    end
                end
            end
        end else s_lat = 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int nb(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit legal(input bit st, input logic [2:0] f3);
        if (st) return f3 < 3'd3;
        return !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    endfunction

    function automatic logic [31:0] ref_load(input int a, input logic [2:0] f3);
        longint unsigned v = 0;
        int n = nb(f3);
        for (int i = 0; i < n; i++) v = v | (longint'(rmem[a+i]) << (8*i));
        if (!f3[2] && v[8*n-1]) v = v - (64'd1 << (8*n));
        return v[31:0];
    endfunction

    function automatic logic [31:0] exp_dat(input logic [31:0] wd, input int n);
        logic [31:0] d;
        for (int i = 0; i < 4; i++) d[8*i +: 8] = wd[8*(i % n) +: 8];
        return d;
    endfunction

    logic [31:0] r_rd, r_dat, r_adr;
    logic [3:0]  r_sel;
    logic [1:0]  r_cause;
    logic        r_err, r_we;
    int          r_lat, r_rises, r_lows;
    bit          r_stable, r_got;

    // One request: accept, scramble the request inputs, then watch the bus until rsp_valid_o.
    task automatic txn(input bit st, input logic [2:0] f3, input int off, input logic [31:0] wd);
        bit prev = 1'b0, seen = 1'b0;
        r_rises = 0; r_lows = 0; r_stable = 1'b1; r_got = 1'b0; r_lat = 0;
        @(negedge clk_i);
        req_valid_i = 1'b1; req_store_i = st; req_funct3_i = f3;
        req_addr_i = BASE + 32'(off); req_wdata_i = wd;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0; req_store_i = 1'($urandom); req_funct3_i = 3'($urandom);
        req_addr_i = $urandom; req_wdata_i = $urandom;
        for (int c = 1; c <= 400 && !r_got; c++) begin
            @(negedge clk_i);
            if (rsp_valid_o) begin
                r_got = 1'b1; r_lat = c;
                r_rd = rsp_rdata_o; r_err = rsp_err_o; r_cause = rsp_cause_o;
                chk("ready_low_in_resp", 32'(req_ready_o), 32'd0);
            end else if (cyc_o) begin
                if (!prev) r_rises++;
                if (!seen) begin
                    seen = 1'b1; r_sel = sel_o; r_dat = dat_o; r_adr = adr_o; r_we = we_o;
                end else if (sel_o !== r_sel || dat_o !== r_dat || adr_o !== r_adr || we_o !== r_we)
                    r_stable = 1'b0;
            end else if (seen) r_lows++;
            prev = cyc_o;
        end
        chk("rsp_seen", 32'(r_got), 32'd1);
    endtask

    task automatic run_check(input bit st, input logic [2:0] f3, input int off,
                             input logic [31:0] wd, input int dly, input int rty);
        int n;
        logic [31:0] exp_rd;
        s_delay = dly; s_rty = rty;
        exp_rd = '0;
        n = nb(f3);
        if (legal(st, f3) && (off % n) == 0 && !st) exp_rd = ref_load(off, f3);
        txn(st, f3, off, wd);
        if (!legal(st, f3)) begin
            chk("ill_err", 32'(r_err), 32'd1);
            chk("ill_cause", 32'(r_cause), 32'd1);
            chk("ill_nobus", 32'(r_rises), 32'd0);
            chk("ill_lat", 32'(r_lat), 32'd1);
        end else if ((off % n) != 0) begin
            chk("mis_err", 32'(r_err), 32'd1);
            chk("mis_cause", 32'(r_cause), 32'd0);
            chk("mis_nobus", 32'(r_rises), 32'd0);
            chk("mis_lat", 32'(r_lat), 32'd1);
            chk("mis_rdata", r_rd, 32'd0);
        end else begin
            chk("ok_err", 32'(r_err), 32'd0);
            chk("ok_issues", 32'(r_rises), 32'(rty + 1));
            chk("ok_sel", 32'(r_sel), 32'(((1 << n) - 1) << (off % 4)));
            chk("ok_adr", r_adr, BASE + 32'(off & ~3));
            chk("ok_we", 32'(r_we), 32'(st));
            chk("ok_stable", 32'(r_stable), 32'd1);
            chk("ok_rdata", r_rd, exp_rd);
            if (rty == 0) chk("ok_lat", 32'(r_lat), 32'(2 + dly));
            if (st) begin
                chk("st_dat", r_dat, exp_dat(wd, n));
                for (int i = 0; i < n; i++) rmem[off+i] = wd[8*i +: 8];
            end
        end
    endtask

    task automatic set_word(input int w, input logic [31:0] v);
        smem[w] = v;
        for (int i = 0; i < 4; i++) rmem[4*w+i] = v[8*i +: 8];
    endtask

    initial begin
        bit no_rsp;
        set_word(0, 32'h8382_8180);
        for (int w = 1; w < 16; w++) set_word(w, $urandom);

        repeat (2) @(negedge clk_i);
        chk("rst_cyc", 32'(cyc_o), 32'd0);
        chk("rst_stb", 32'(stb_o), 32'd0);
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_adr", adr_o, 32'd0);
        chk("rst_sel", 32'(sel_o), 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("rst_rsp_cause", 32'(rsp_cause_o), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_ready", 32'(req_ready_o), 32'd1);

        run_check(1'b0, 3'b000, 0, 32'd0, 0, 0);
        chk("t1_lb_sel", 32'(r_sel), 32'h1);
        chk("t1_lb", r_rd, 32'hFFFF_FF80);
        run_check(1'b0, 3'b100, 0, 32'd0, 1, 0);
        chk("t1_lbu", r_rd, 32'h0000_0080);
        run_check(1'b0, 3'b001, 2, 32'd0, 0, 0);
        chk("t2_lh_sel", 32'(r_sel), 32'hC);
        chk("t2_lh", r_rd, 32'hFFFF_8382);
        run_check(1'b0, 3'b101, 2, 32'd0, 2, 0);
        chk("t2_lhu", r_rd, 32'h0000_8382);

        set_word(0, 32'hDEAD_BEEF);
        run_check(1'b1, 3'b000, 3, 32'hF3F2_F1F0, 0, 0);
        chk("t3_sel", 32'(r_sel), 32'h8);
        chk("t3_dat", r_dat, 32'hF0F0_F0F0);
        chk("t3_word0", smem[0], 32'hF0AD_BEEF);
        chk("t3_rdata_store", r_rd, 32'd0);

        run_check(1'b0, 3'b010, 2, 32'd0, 0, 0);
        chk("t4_mis_cause", 32'(r_cause), 32'd0);
        run_check(1'b1, 3'b100, 0, 32'h1234_5678, 0, 0);
        chk("t4_ill_cause", 32'(r_cause), 32'd1);

        s_delay = 0; s_rty = 4;
        txn(1'b0, 3'b010, 8, 32'd0);
        chk("t5_rty_err", 32'(r_err), 32'd1);
        chk("t5_rty_cause", 32'(r_cause), 32'd3);
        chk("t5_rty_issues", 32'(r_rises), 32'd4);
        chk("t5_rty_gaps", 32'(r_lows), 32'd3);
        chk("t5_rty_stable", 32'(r_stable), 32'd1);
        s_rty = 0;
        run_check(1'b0, 3'b010, 8, 32'd0, 0, 3);
        s_both = 1'b1;
        run_check(1'b0, 3'b010, 4, 32'd0, 0, 0);
        s_both = 1'b0;

        s_noresp = 1'b1;
        txn(1'b0, 3'b010, 12, 32'd0);
        chk("to_err", 32'(r_err), 32'd1);
        chk("to_cause", 32'(r_cause), 32'd2);
        chk("to_lat", 32'(r_lat), 32'd256);

        @(negedge clk_i);
        req_valid_i = 1'b1; req_store_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = BASE;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("t6_cyc_before", 32'(cyc_o), 32'd1);
        rst_i = 1'b1; #1;
        chk("t6_cyc_reset", 32'(cyc_o), 32'd0);
        chk("t6_stb_reset", 32'(stb_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0; s_noresp = 1'b0;
        no_rsp = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            if (rsp_valid_o) no_rsp = 1'b0;
        end
        chk("t6_no_rsp", 32'(no_rsp), 32'd1);
        run_check(1'b0, 3'b010, 0, 32'd0, 0, 0);

        for (int k = 0; k < 60; k++) begin
            bit st;
            logic [2:0] f3;
            int off;
            st = 1'($urandom);
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
            else if (st) f3 = 3'($urandom_range(0, 2));
            else case ($urandom_range(0, 4))
                0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
            endcase
            off = $urandom_range(0, 60);
            if ($urandom_range(0, 7) != 0 && f3[1:0] != 2'b11) off = off & ~(nb(f3) - 1);
            run_check(st, f3, off, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        for (int w = 0; w < 16; w++)
            chk("mem_final", smem[w], {rmem[4*w+3], rmem[4*w+2], rmem[4*w+1], rmem[4*w]});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
